// File: rtl/mul8_pp_pipe.sv
// Purpose : two-stage register shell around an external 8x8 unsigned GPC compressor tree.
//           S1 registers the 64 partial-product bits as 15 column bundles; S2 captures the
//           compressor's 16 column results as the registered product.
// Latency : a pair accepted at edge N drives pp_col* after N; prod_o/out_valid follow after N+1.
// Backpr. : valid/ready per stage; in_ready falls only when both stages are full and out_ready=0.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake for a_i, b_i (8-bit unsigned)
//   pp_col0..pp_col14   registered partial-product column k (to compressor src k),
//                       width min(k+1,15-k), bit 0 = lowest multiplicand index i
//   cmp_dst             compressor results, bit k = column k result
//   out_valid/out_ready product handshake for prod_o
//   res_cnt             wrapping count of products handed off (CNT_W bits)
//   chk_err             sticky self-check flag, only with `define MUL8_PP_CHECK_EN
module mul8_pp_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a_i,
    input  logic [7:0]       b_i,
    output logic [0:0]       pp_col0,
    output logic [1:0]       pp_col1,
    output logic [2:0]       pp_col2,
    output logic [3:0]       pp_col3,
    output logic [4:0]       pp_col4,
    output logic [5:0]       pp_col5,
    output logic [6:0]       pp_col6,
    output logic [7:0]       pp_col7,
    output logic [6:0]       pp_col8,
    output logic [5:0]       pp_col9,
    output logic [4:0]       pp_col10,
    output logic [3:0]       pp_col11,
    output logic [2:0]       pp_col12,
    output logic [1:0]       pp_col13,
    output logic [0:0]       pp_col14,
    input  logic [15:0]      cmp_dst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      prod_o,
    output logic [CNT_W-1:0] res_cnt
`ifdef MUL8_PP_CHECK_EN
    ,
    output logic             chk_err
`endif
);

    logic        s1_valid;
    logic        s1_ready;
    logic        s2_ready;
    logic        s1_load;
    logic        s2_load;
    logic [63:0] pp_d;
    logic [63:0] pp_q;

    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    // Held low while reset is asserted so every output reads 0 during reset.
    assign in_ready = s1_ready && !rst;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s1_valid && s2_ready;

    // Pack columns back to back, k ascending, and within a column i ascending.
    always_comb begin
        int n;
        pp_d = '0;
        n    = 0;
        for (int k = 0; k < 15; k++) begin
            for (int i = 0; i < 8; i++) begin
                if ((k - i >= 0) && (k - i <= 7)) begin
                    pp_d[n[5:0]] = a_i[i[2:0]] & b_i[3'(k - i)];
                    n++;
                end
            end
        end
    end

    // Column k starts at the sum of the widths of columns 0..k-1.
    assign pp_col0  = pp_q[0:0];
    assign pp_col1  = pp_q[2:1];
    assign pp_col2  = pp_q[5:3];
    assign pp_col3  = pp_q[9:6];
    assign pp_col4  = pp_q[14:10];
    assign pp_col5  = pp_q[20:15];
    assign pp_col6  = pp_q[27:21];
    assign pp_col7  = pp_q[35:28];
    assign pp_col8  = pp_q[42:36];
    assign pp_col9  = pp_q[48:43];
    assign pp_col10 = pp_q[53:49];
    assign pp_col11 = pp_q[57:54];
    assign pp_col12 = pp_q[60:58];
    assign pp_col13 = pp_q[62:61];
    assign pp_col14 = pp_q[63:63];

    // Stage 1: PP registers hold when not loading, including after S1 drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            pp_q     <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            pp_q     <= pp_d;
        end else if (s2_ready) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: prod_o only changes on a load, so it is stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            prod_o    <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            prod_o    <= cmp_dst;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_cnt <= '0;
        end else if (out_valid && out_ready) begin
            res_cnt <= res_cnt + 1'b1;
        end
    end

`ifdef MUL8_PP_CHECK_EN
    // Operand shadows travel with the PP bits so the compressor result can be
    // compared against a reference product at the moment S2 captures it.
    logic [7:0] a_q;
    logic [7:0] b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (s1_load) begin
            a_q <= a_i;
            b_q <= b_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_err <= 1'b0;
        end else if (s2_load && (cmp_dst != (16'(a_q) * 16'(b_q)))) begin
            chk_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mul8_pp_pipe.sv
// Bench for mul8_pp_pipe: models the external compressor as a weighted popcount of the
// PP columns (with an optional fault mask), drives directed vectors and checks the
// handshake, latency, backpressure, column mapping, counter wrap and reset behaviour.
module tb_mul8_pp_pipe;

    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    a_i;
    logic [7:0]    b_i;
    logic [0:0]    pp_col0;
    logic [1:0]    pp_col1;
    logic [2:0]    pp_col2;
    logic [3:0]    pp_col3;
    logic [4:0]    pp_col4;
    logic [5:0]    pp_col5;
    logic [6:0]    pp_col6;
    logic [7:0]    pp_col7;
    logic [6:0]    pp_col8;
    logic [5:0]    pp_col9;
    logic [4:0]    pp_col10;
    logic [3:0]    pp_col11;
    logic [2:0]    pp_col12;
    logic [1:0]    pp_col13;
    logic [0:0]    pp_col14;
    logic [15:0]   cmp_dst;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   prod_o;
    logic [CW-1:0] res_cnt;
`ifdef MUL8_PP_CHECK_EN
    logic          chk_err;
`endif
    logic [15:0]   fault;

    int n_tests = 0;
    int n_fail  = 0;

    mul8_pp_pipe #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .pp_col0   (pp_col0),
        .pp_col1   (pp_col1),
        .pp_col2   (pp_col2),
        .pp_col3   (pp_col3),
        .pp_col4   (pp_col4),
        .pp_col5   (pp_col5),
        .pp_col6   (pp_col6),
        .pp_col7   (pp_col7),
        .pp_col8   (pp_col8),
        .pp_col9   (pp_col9),
        .pp_col10  (pp_col10),
        .pp_col11  (pp_col11),
        .pp_col12  (pp_col12),
        .pp_col13  (pp_col13),
        .pp_col14  (pp_col14),
        .cmp_dst   (cmp_dst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod_o    (prod_o),
        .res_cnt   (res_cnt)
`ifdef MUL8_PP_CHECK_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compressor stand-in: each PP bit in column k is worth 2^k.
    always_comb begin
        logic [15:0] acc;
        acc = 16'($countones(pp_col0))
            + (16'($countones(pp_col1))  << 1)
            + (16'($countones(pp_col2))  << 2)
            + (16'($countones(pp_col3))  << 3)
            + (16'($countones(pp_col4))  << 4)
            + (16'($countones(pp_col5))  << 5)
            + (16'($countones(pp_col6))  << 6)
            + (16'($countones(pp_col7))  << 7)
            + (16'($countones(pp_col8))  << 8)
            + (16'($countones(pp_col9))  << 9)
            + (16'($countones(pp_col10)) << 10)
            + (16'($countones(pp_col11)) << 11)
            + (16'($countones(pp_col12)) << 12)
            + (16'($countones(pp_col13)) << 13)
            + (16'($countones(pp_col14)) << 14);
        cmp_dst = acc ^ fault;
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] col7_model(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = a[j] & b[7 - j];
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] exp_cnt;
        logic          others;

        vecs[0] = '{a: 8'h03, b: 8'h05, p: 16'h000F};
        vecs[1] = '{a: 8'h80, b: 8'h02, p: 16'h0100};
        vecs[2] = '{a: 8'h00, b: 8'hAB, p: 16'h0000};
        vecs[3] = '{a: 8'h10, b: 8'h10, p: 16'h0100};
        vecs[4] = '{a: 8'hFF, b: 8'h01, p: 16'h00FF};
        vecs[5] = '{a: 8'hAA, b: 8'h55, p: 16'h3872};
        vecs[6] = '{a: 8'h0F, b: 8'hF0, p: 16'h0E10};
        vecs[7] = '{a: 8'hC3, b: 8'h3C, p: 16'h2DB4};

        rst = 1'b1; in_valid = 1'b0; a_i = '0; b_i = '0; out_ready = 1'b1; fault = '0;
        exp_cnt = '0;

        // Reset state
        step(); step();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_prod",      32'(prod_o),    0);
        check("rst_res_cnt",   32'(res_cnt),   0);
        check("rst_in_ready",  32'(in_ready),  0);
        check("rst_pp_col7",   32'(pp_col7),   0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", 32'(in_ready), 1);

        // Single op 0xFF*0xFF: exact latency and counter
        a_i = 8'hFF; b_i = 8'hFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("single_vld_n",  32'(out_valid), 0);
        check("single_col7",   32'(pp_col7),   32'h00FF);
        step();
        check("single_vld_n1", 32'(out_valid), 1);
        check("single_prod",   32'(prod_o),    32'hFE01);
        step();
        exp_cnt = exp_cnt + 1'b1;
        check("single_cnt",    32'(res_cnt),   32'(exp_cnt));
        check("single_drain",  32'(out_valid), 0);

        // Back-to-back table stream, one result per cycle
        for (int i = 0; i < 8; i++) begin
            a_i = vecs[i].a; b_i = vecs[i].b; in_valid = 1'b1;
            #1;
            check($sformatf("stream_rdy%0d", i), 32'(in_ready), 1);
            step();
            check($sformatf("stream_col7_%0d", i), 32'(pp_col7), 32'(col7_model(vecs[i].a, vecs[i].b)));
            if (i > 0) begin
                check($sformatf("stream_vld%0d", i - 1), 32'(out_valid), 1);
                check($sformatf("stream_prod%0d", i - 1), 32'(prod_o), 32'(vecs[i - 1].p));
            end
        end
        in_valid = 1'b0;
        step();
        check("stream_vld7",  32'(out_valid), 1);
        check("stream_prod7", 32'(prod_o),    32'(vecs[7].p));
        step();
        exp_cnt = exp_cnt + 3'(8);
        check("stream_cnt_wrap", 32'(res_cnt), 32'(exp_cnt));

        // Backpressure: three offered, two accepted, prod_o stable, drain in order
        out_ready = 1'b0;
        a_i = 8'h11; b_i = 8'h11; in_valid = 1'b1;
        step();
        a_i = 8'h12; b_i = 8'h03;
        #1;
        check("bp_rdy_second", 32'(in_ready), 1);
        step();
        a_i = 8'h0F; b_i = 8'h0F;
        #1;
        check("bp_rdy_full", 32'(in_ready), 0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("bp_hold_prod%0d", c), 32'(prod_o),   32'h0121);
            check($sformatf("bp_hold_rdy%0d", c),  32'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        check("bp_drain1", 32'(prod_o), 32'h0036);
        step();
        check("bp_drain2", 32'(prod_o), 32'h00E1);
        step();
        check("bp_drain_vld", 32'(out_valid), 0);
        exp_cnt = exp_cnt + 3'(3);
        check("bp_cnt", 32'(res_cnt), 32'(exp_cnt));

        // Column mapping: only pp_col7[0] set
        a_i = 8'h01; b_i = 8'h80; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        others = |{pp_col0, pp_col1, pp_col2, pp_col3, pp_col4, pp_col5, pp_col6,
                   pp_col8, pp_col9, pp_col10, pp_col11, pp_col12, pp_col13, pp_col14};
        check("col_map_col7",   32'(pp_col7), 32'h01);
        check("col_map_others", 32'(others),  0);
        step();
        check("col_map_prod", 32'(prod_o), 32'h0080);
        step();
        exp_cnt = exp_cnt + 1'b1;
        check("col_map_cnt",       32'(res_cnt), 32'(exp_cnt));
        check("held_pp_after",     32'(pp_col7), 32'h01);
        check("held_prod_after",   32'(prod_o),  32'h0080);

`ifdef MUL8_PP_CHECK_EN
        // Corrupted compressor bit 3 for one op sets the sticky flag
        check("chk_clean", 32'(chk_err), 0);
        fault = 16'h0008;
        a_i = 8'h07; b_i = 8'h09; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        fault = '0;
        check("chk_rise", 32'(chk_err), 1);
        a_i = 8'h02; b_i = 8'h03; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        exp_cnt = exp_cnt + 3'(2);
        check("chk_sticky", 32'(chk_err), 1);
        check("chk_cnt",    32'(res_cnt), 32'(exp_cnt));
`endif

        // Reset with both stages full
        out_ready = 1'b0;
        a_i = 8'h21; b_i = 8'h02; in_valid = 1'b1;
        step();
        a_i = 8'h05; b_i = 8'h05;
        step();
        in_valid = 1'b0;
        check("mid_full_vld", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_vld",  32'(out_valid), 0);
        check("mid_rst_prod", 32'(prod_o),    0);
        check("mid_rst_cnt",  32'(res_cnt),   0);
        check("mid_rst_col7", 32'(pp_col7),   0);
`ifdef MUL8_PP_CHECK_EN
        check("mid_rst_chk",  32'(chk_err),   0);
`endif
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mid_rel_rdy", 32'(in_ready), 1);
        step();
        check("mid_no_partial", 32'(out_valid), 0);
        check("mid_cnt_after",  32'(res_cnt),   0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
